// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: walks the PC, fetches one
// instruction at a time over a req/ack handshake, and absorbs decode stalls and redirects.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr
);

   typedef enum logic [1:0] {
      S_REQ  = 2'b00,
      S_HOLD = 2'b01,
      S_DROP = 2'b10
   } state_t;

   state_t      state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] drop_addr_r, drop_addr_s;
   logic [31:0] hold_pc_r, hold_pc_s;
   logic [31:0] hold_instr_r, hold_instr_s;
   logic        valid_r, valid_s;
   logic [31:0] ifpc_r, ifpc_s;
   logic [31:0] instr_r, instr_s;
   logic        slot_free_s;

   assign slot_free_s = !valid_r || !id_stall;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_REQ;
         pc_r         <= RESET_PC;
         drop_addr_r  <= 32'h0000_0000;
         hold_pc_r    <= 32'h0000_0000;
         hold_instr_r <= 32'h0000_0000;
         valid_r      <= 1'b0;
         ifpc_r       <= 32'h0000_0000;
         instr_r      <= NOP_INSTR;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         drop_addr_r  <= drop_addr_s;
         hold_pc_r    <= hold_pc_s;
         hold_instr_r <= hold_instr_s;
         valid_r      <= valid_s;
         ifpc_r       <= ifpc_s;
         instr_r      <= instr_s;
      end
   end

   // Next-state and next-datapath logic; a redirect outranks stall and ack
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      drop_addr_s  = drop_addr_r;
      hold_pc_s    = hold_pc_r;
      hold_instr_s = hold_instr_r;
      valid_s      = valid_r;
      ifpc_s       = ifpc_r;
      instr_s      = instr_r;
      if (redirect_valid) begin
         valid_s      = 1'b0;
         instr_s      = NOP_INSTR;
         hold_pc_s    = 32'h0000_0000;
         hold_instr_s = 32'h0000_0000;
         pc_s         = {redirect_pc[31:2], 2'b00};
         case (state_r)
            S_REQ: begin
               if (imem_ack) begin
                  state_s = S_REQ;
               end else begin
                  // The memory still owes us the old request; keep its address on the bus
                  state_s     = S_DROP;
                  drop_addr_s = pc_r;
               end
            end
            S_HOLD:  state_s = S_REQ;
            S_DROP:  state_s = S_DROP;
            default: state_s = S_REQ;
         endcase
      end else begin
         case (state_r)
            S_REQ: begin
               if (imem_ack) begin
                  pc_s = pc_r + 32'd4;
                  if (slot_free_s) begin
                     valid_s = 1'b1;
                     ifpc_s  = pc_r;
                     instr_s = imem_rdata;
                  end else begin
                     hold_pc_s    = pc_r;
                     hold_instr_s = imem_rdata;
                     state_s      = S_HOLD;
                  end
               end else if (slot_free_s) begin
                  valid_s = 1'b0;
                  instr_s = NOP_INSTR;
               end else begin
                  valid_s = valid_r;
               end
            end
            S_HOLD: begin
               if (!id_stall) begin
                  valid_s = 1'b1;
                  ifpc_s  = hold_pc_r;
                  instr_s = hold_instr_r;
                  state_s = S_REQ;
               end else begin
                  state_s = S_HOLD;
               end
            end
            S_DROP: begin
               if (imem_ack) begin
                  state_s = S_REQ;
               end else begin
                  state_s = S_DROP;
               end
               if (slot_free_s) begin
                  valid_s = 1'b0;
                  instr_s = NOP_INSTR;
               end else begin
                  valid_s = valid_r;
               end
            end
            default: state_s = S_REQ;
         endcase
      end
   end

   // Memory request outputs decoded from state
   always_comb begin
      case (state_r)
         S_REQ: begin
            imem_req  = 1'b1;
            imem_addr = pc_r;
         end
         S_DROP: begin
            imem_req  = 1'b1;
            imem_addr = drop_addr_r;
         end
         S_HOLD: begin
            imem_req  = 1'b0;
            imem_addr = pc_r;
         end
         default: begin
            imem_req  = 1'b0;
            imem_addr = pc_r;
         end
      endcase
      if (rst) begin
         imem_req = 1'b0;
      end else begin
         imem_req = imem_req;
      end
   end

   assign if_id_valid = valid_r;
   assign if_id_pc    = ifpc_r;
   assign if_id_instr = instr_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all checked
// cycle by cycle against a transaction-level model of the fetch stage.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0000_0000;
   logic        id_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0000_0000;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;

   int errors = 0;
   int checks = 0;

   // model state: architectural PC, IF/ID contents, pending (held) fetches, wrong-path request
   logic [31:0] m_pc = RESET_PC;
   logic        m_valid = 1'b0;
   logic [31:0] m_ifpc = 32'h0000_0000;
   logic [31:0] m_instr = NOP_INSTR;
   logic        m_wrong = 1'b0;
   logic [31:0] m_wrong_addr = 32'h0000_0000;
   logic [31:0] pend_pc[$];
   logic [31:0] pend_instr[$];

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .id_stall(id_stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: mem_word = 32'h0050_0093;
         32'h0000_0004: mem_word = 32'h00a0_0113;
         32'h0000_0008: mem_word = 32'h00f0_0193;
         default:       mem_word = (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
      endcase
   endfunction

   // One clock: drive inputs, check outputs, then advance the model across the edge.
   task automatic step(input logic r, input logic a, input logic s, input logic rv, input logic [31:0] rp);
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        ack_eff;
      logic        free;
      @(negedge clk);
      exp_req  = !r && (pend_pc.size() == 0);
      exp_addr = m_wrong ? m_wrong_addr : m_pc;
      ack_eff  = a && exp_req;
      rst            = r;
      imem_ack       = ack_eff;
      imem_rdata     = ack_eff ? mem_word(exp_addr) : $urandom;
      id_stall       = s;
      redirect_valid = rv;
      redirect_pc    = rp;
      #1;
      check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) check_eq("imem_addr", imem_addr, exp_addr);
      check_eq("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      check_eq("if_id_pc", if_id_pc, m_ifpc);
      check_eq("if_id_instr", if_id_instr, m_instr);

      if (r) begin
         m_pc = RESET_PC; m_valid = 1'b0; m_ifpc = 32'h0000_0000; m_instr = NOP_INSTR;
         m_wrong = 1'b0; pend_pc.delete(); pend_instr.delete();
      end else if (rv) begin
         if (exp_req && !ack_eff && !m_wrong) begin
            m_wrong = 1'b1; m_wrong_addr = m_pc;
         end
         pend_pc.delete(); pend_instr.delete();
         m_pc = rp & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = NOP_INSTR;
      end else begin
         free = !m_valid || !s;
         if (pend_pc.size() > 0) begin
            if (!s) begin
               m_ifpc = pend_pc.pop_front(); m_instr = pend_instr.pop_front(); m_valid = 1'b1;
            end
         end else if (ack_eff) begin
            if (m_wrong) begin
               m_wrong = 1'b0;
               if (free) begin m_valid = 1'b0; m_instr = NOP_INSTR; end
            end else begin
               if (free) begin
                  m_valid = 1'b1; m_ifpc = m_pc; m_instr = imem_rdata;
               end else begin
                  pend_pc.push_back(m_pc); pend_instr.push_back(imem_rdata);
               end
               m_pc = m_pc + 32'd4;
            end
         end else if (free) begin
            m_valid = 1'b0; m_instr = NOP_INSTR;
         end
      end
   endtask

   task automatic after_edge;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        r, a, s, rv;
      logic [31:0] rp;
      repeat (2) @(posedge clk);

      // back-to-back fetches from reset
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      after_edge();
      check_eq("plan_seq_pc", if_id_pc, 32'h0000_0008);
      check_eq("plan_seq_instr", if_id_instr, 32'h00f0_0193);

      // stall while pc 0x4 acks, then release
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      after_edge();
      check_eq("plan_hold_req", {31'd0, imem_req}, 32'd0);
      check_eq("plan_hold_pc", if_id_pc, 32'h0000_0000);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      after_edge();
      check_eq("plan_release_pc", if_id_pc, 32'h0000_0004);
      check_eq("plan_release_addr", imem_addr, 32'h0000_0008);

      // redirect while the 0x8 request is outstanding
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
      after_edge();
      check_eq("plan_drop_addr", imem_addr, 32'h0000_0008);
      check_eq("plan_drop_instr", if_id_instr, NOP_INSTR);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      after_edge();
      check_eq("plan_drop_valid", {31'd0, if_id_valid}, 32'd0);
      check_eq("plan_new_addr", imem_addr, 32'h0000_0100);

      // redirect coincident with ack
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
      after_edge();
      check_eq("plan_redir_ack_addr", imem_addr, 32'h0000_0200);
      check_eq("plan_redir_ack_valid", {31'd0, if_id_valid}, 32'd0);

      // PC wraparound
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      after_edge();
      check_eq("plan_wrap_pc0", if_id_pc, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      after_edge();
      check_eq("plan_wrap_pc1", if_id_pc, 32'h0000_0000);

      // reset while waiting at 0x10
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      after_edge();
      check_eq("plan_rst_req", {31'd0, imem_req}, 32'd0);
      check_eq("plan_rst_valid", {31'd0, if_id_valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 99) == 0);
         a  = ($urandom_range(0, 1) == 1);
         s  = ($urandom_range(0, 2) == 0);
         rv = ($urandom_range(0, 9) == 0);
         rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'h0000_000F)) : $urandom;
         step(r, a, s, rv, rp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
